// File: rtl/vga_rx.sv
// vga_rx: receive side of the VGA link. Registers R/G/B and the syncs, recovers
// line/frame timing, measures htotal/vtotal, tracks timing stability with a
// SEARCH/CHECK/LOCKED machine and emits active-area pixels with x/y and
// frame/line markers.
// Optional build macro VGA_RX_POLARITY_DETECT_EN: sync polarity is measured
// from the incoming signals instead of taken from hpp/vpp, and reported on
// hpol_o/vpol_o.
// Stream handshake: valid is a one-cycle qualifier with no back-pressure; when
// valid is high, data/x/y/sof/sol describe one active pixel in that cycle.
module vga_rx #(
   parameter int hva = 1920,
   parameter int hsb = 70,
   parameter int vva = 1080,
   parameter int vsb = 41,
   parameter int hpp = 1,
   parameter int vpp = 1,
   parameter int rd  = 5,
   parameter int gd  = 6,
   parameter int bd  = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [rd-1:0]       R,
   input  logic [gd-1:0]       G,
   input  logic [bd-1:0]       B,
   input  logic                HSync,
   input  logic                VSync,
   output logic [rd+gd+bd-1:0] data,
   output logic                valid,
   output logic [11:0]         x,
   output logic [10:0]         y,
   output logic                sof,
   output logic                sol,
   output logic [11:0]         htotal,
   output logic [10:0]         vtotal,
   output logic                locked
`ifdef VGA_RX_POLARITY_DETECT_EN
   ,
   output logic                hpol_o,
   output logic                vpol_o
`endif
);

   localparam int pw = rd + gd + bd;
   localparam logic [11:0] h_start = 12'(hsb);
   localparam logic [11:0] h_end   = 12'(hsb + hva);
   localparam logic [10:0] v_start = 11'(vsb);
   localparam logic [10:0] v_end   = 11'(vsb + vva);

   typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

   state_t          state, state_nx;
   logic [pw-1:0]   pix1;
   logic            hs1, hs2, vs1, vs2;
   logic            h_lvl, v_lvl;
   logic            hs_lead, vs_lead;
   logic [11:0]     hc;
   logic [10:0]     vc;
   logic            vpend;
   logic [11:0]     h_meas, ref_h;
   logic [10:0]     v_meas, ref_v;
   logic            vrst, tout, h_bad, v_bad, pol_chg;
   logic            dirty, frame_ok;
   logic            h_win, v_win, at_origin, emit;

   // Stage 1 holds every input, stage 2 holds the syncs for edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pix1 <= '0;
         hs1  <= 1'b0;
         hs2  <= 1'b0;
         vs1  <= 1'b0;
         vs2  <= 1'b0;
      end else begin
         pix1 <= {R, G, B};
         hs1  <= HSync;
         hs2  <= hs1;
         vs1  <= VSync;
         vs2  <= vs1;
      end
   end

`ifdef VGA_RX_POLARITY_DETECT_EN
   logic       hs_rise, vs_rise, h_min, v_min, hpol_meas;
   logic [1:0] h_seen, v_seen;
   logic [11:0] h_hi, h_per, v_hi, v_per;

   assign hs_rise = hs1 && !hs2;
   assign vs_rise = vs1 && !vs2;
   // The level held for less than half the period is the active one
   assign h_min   = ({h_hi, 1'b0} < {1'b0, h_per});
   assign v_min   = ({v_hi, 1'b0} < {1'b0, v_per});
   assign h_lvl   = hpol_o;
   assign v_lvl   = vpol_o;
   // A period only counts once two rising edges have been seen, since the
   // first one may be an artefact of the cleared input stage.
   assign pol_chg = vs_rise && (v_seen == 2'd2) &&
                    ((hpol_meas != hpol_o) || (v_min != vpol_o));

   // HSync high time over one rising-edge-to-rising-edge period, in clocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_hi      <= '0;
         h_per     <= '0;
         h_seen    <= '0;
         hpol_meas <= 1'b0;
      end else if (hs_rise) begin
         if (h_seen == 2'd2) hpol_meas <= h_min;
         else                h_seen    <= h_seen + 2'd1;
         h_hi  <= 12'd1;
         h_per <= 12'd1;
      end else begin
         if (h_per != 12'hFFF)       h_per <= h_per + 12'd1;
         if (hs1 && h_hi != 12'hFFF) h_hi  <= h_hi + 12'd1;
      end
   end

   // VSync high time in lines; both polarities are committed once per frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_hi   <= '0;
         v_per  <= '0;
         v_seen <= '0;
         hpol_o <= 1'b0;
         vpol_o <= 1'b0;
      end else if (vs_rise) begin
         if (v_seen == 2'd2) begin
            hpol_o <= hpol_meas;
            vpol_o <= v_min;
         end else begin
            v_seen <= v_seen + 2'd1;
         end
         v_hi  <= '0;
         v_per <= '0;
      end else if (hs_rise) begin
         if (v_per != 12'hFFF)       v_per <= v_per + 12'd1;
         if (vs1 && v_hi != 12'hFFF) v_hi  <= v_hi + 12'd1;
      end
   end
`else
   assign h_lvl   = 1'(hpp);
   assign v_lvl   = 1'(vpp);
   assign pol_chg = 1'b0;
`endif

   assign hs_lead   = (hs1 == h_lvl) && (hs2 != h_lvl);
   assign vs_lead   = (vs1 == v_lvl) && (vs2 != v_lvl);
   assign h_meas    = hc + 12'd1;
   assign v_meas    = vc + 11'd1;
   assign vrst      = hs_lead && vpend;
   assign tout      = (hc == 12'hFFF);
   assign h_bad     = hs_lead && (h_meas != ref_h);
   assign v_bad     = vrst && (v_meas != ref_v);
   assign h_win     = (hc >= h_start) && (hc < h_end);
   assign v_win     = (vc >= v_start) && (vc < v_end);
   assign at_origin = (hc == h_start) && (vc == v_start);
   // A frame is emitted only if locking happened before its first pixel
   assign emit      = locked && h_win && v_win && (frame_ok || at_origin);

   // Line/frame counters and timing measurement; a stalled HSync clears totals
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hc     <= '0;
         vc     <= '0;
         vpend  <= 1'b0;
         htotal <= '0;
         vtotal <= '0;
      end else begin
         if (hs_lead)    hc <= '0;
         else if (!tout) hc <= hc + 12'd1;
         if (hs_lead) begin
            htotal <= h_meas;
            if (vpend) begin
               vc     <= '0;
               vtotal <= v_meas;
            end else if (vc != 11'h7FF) begin
               vc <= vc + 11'd1;
            end
         end
         // A VSync edge coinciding with an HSync edge waits for the next line
         if (vs_lead)   vpend <= 1'b1;
         else if (vrst) vpend <= 1'b0;
         if (tout) begin
            htotal <= '0;
            vtotal <= '0;
         end
      end
   end

   // Lock machine: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SEARCH;
      else     state <= state_nx;
   end

   // Lock machine: next state
   always_comb begin
      state_nx = state;
      case (state)
         SEARCH: if (vrst) state_nx = CHECK;
         CHECK:  if (vrst && !dirty && !h_bad && !v_bad && (v_meas >= v_end))
                    state_nx = LOCKED;
         LOCKED: if (h_bad || v_bad) state_nx = SEARCH;
         default: state_nx = SEARCH;
      endcase
      if (tout || pol_chg) state_nx = SEARCH;
   end

   // Lock machine: outputs
   always_comb begin
      locked = (state == LOCKED);
   end

   // Reference timing used to judge the next frame while searching/checking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_h <= '0;
         ref_v <= '0;
         dirty <= 1'b0;
      end else if ((state == SEARCH || state == CHECK) && vrst) begin
         ref_h <= h_meas;
         ref_v <= v_meas;
         dirty <= 1'b0;
      end else if (state == CHECK && h_bad) begin
         ref_h <= h_meas;
         dirty <= 1'b1;
      end
   end

   // Frame gate: opens at the first pixel of a frame seen while locked
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            frame_ok <= 1'b0;
      else if (!locked)   frame_ok <= 1'b0;
      else if (at_origin) frame_ok <= 1'b1;
   end

   // Output stage: pixel from stage 1 with its coordinates and markers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data  <= '0;
         valid <= 1'b0;
         x     <= '0;
         y     <= '0;
         sol   <= 1'b0;
         sof   <= 1'b0;
      end else begin
         data  <= pix1;
         valid <= emit;
         x     <= emit ? (hc - h_start) : '0;
         y     <= emit ? (vc - v_start) : '0;
         sol   <= emit && (hc == h_start);
         sof   <= emit && at_origin;
      end
   end

endmodule

// File: tb/tb_vga_rx.sv
// tb_vga_rx: randomized pixel stream with small timing (8x4 active, 16x8 total)
// checked through an expected-pixel queue. Lock behaviour is predicted per
// frame: a frame is emitted only when the two frame measurements preceding it
// agree and the receiver has been searching/checking long enough.
module tb_vga_rx;

   localparam int HVA = 8;
   localparam int HSB = 4;
   localparam int VVA = 4;
   localparam int VSB = 2;
   localparam int P   = 16;
   localparam int V   = 8;
   localparam int HSW = 2;
   localparam int VSW = 2;
   localparam int PW  = 16;
   localparam int W   = PW + 12 + 11 + 2;
`ifdef VGA_RX_POLARITY_DETECT_EN
   localparam logic ACT = 1'b0;
`else
   localparam logic ACT = 1'b1;
`endif

   logic          clk, rst;
   logic [4:0]    R;
   logic [5:0]    G;
   logic [4:0]    B;
   logic          HSync, VSync;
   logic [PW-1:0] data;
   logic          valid, sof, sol, locked;
   logic [11:0]   x, htotal;
   logic [10:0]   y, vtotal;
`ifdef VGA_RX_POLARITY_DETECT_EN
   logic          hpol_o, vpol_o;
`endif

   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int sof_n  = 0;
   int sol_n  = 0;

   vga_rx #(.hva(HVA), .hsb(HSB), .vva(VVA), .vsb(VSB), .hpp(1), .vpp(1),
            .rd(5), .gd(6), .bd(5)) dut (
      .clk(clk), .rst(rst), .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync),
      .data(data), .valid(valid), .x(x), .y(y), .sof(sof), .sol(sol),
      .htotal(htotal), .vtotal(vtotal), .locked(locked)
`ifdef VGA_RX_POLARITY_DETECT_EN
      , .hpol_o(hpol_o), .vpol_o(vpol_o)
`endif
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"},  32'(valid),  32'd0);
      check({tag, "_data"},   32'(data),   32'd0);
      check({tag, "_x"},      32'(x),      32'd0);
      check({tag, "_y"},      32'(y),      32'd0);
      check({tag, "_sof"},    32'(sof),    32'd0);
      check({tag, "_sol"},    32'(sol),    32'd0);
      check({tag, "_htotal"}, 32'(htotal), 32'd0);
      check({tag, "_vtotal"}, 32'(vtotal), 32'd0);
      check({tag, "_locked"}, 32'(locked), 32'd0);
   endtask

   // Driver: one input sample per clock, applied just after the active edge
   task automatic drive(input logic [PW-1:0] pix, input logic hs, input logic vs);
      @(posedge clk);
      #1;
      {R, G, B} = pix;
      HSync = hs;
      VSync = vs;
   endtask

   // Asynchronous reset pulse between clock edges, outputs checked at once
   task automatic pulse_reset();
      #2;
      rst = 1'b1;
      #1;
      check_zero("rst_mid");
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // One frame of V lines. Lines before 'sw' are len0 clocks long, the rest
   // len1. HSync and VSync lead together at sample 0 of line 0. The vertical
   // counter restarts on the line after VSync, and both counters run one
   // sample behind the sync edge, so active pixels are samples
   // HSB+1..HSB+HVA of lines VSB+1..VSB+VVA.
   task automatic send_frame(input int len0, input int len1, input int sw,
                             input bit emit, input int rst_line, input int rst_k);
      logic [PW-1:0] pix;
      int len;
      for (int l = 0; l < V; l++) begin
         len = (l < sw) ? len0 : len1;
         for (int k = 0; k < len; k++) begin
            pix = PW'($urandom_range(0, 65535));
            drive(pix, (k < HSW) ? ACT : ~ACT, (l < VSW) ? ACT : ~ACT);
            if (emit && l >= VSB + 1 && l <= VSB + VVA && k >= HSB + 1 && k <= HSB + HVA)
               exp_q.push_back({pix, 12'(k - 1 - HSB), 11'(l - 1 - VSB),
                                (k == HSB + 1) && (l == VSB + 1), (k == HSB + 1)});
            if (l == rst_line && k == rst_k) pulse_reset();
         end
      end
   endtask

   // Scoreboard monitor: every valid pixel must match the head of exp_q
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (valid) begin
            if (sof) sof_n++;
            if (sol) sol_n++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL pixel_unexpected: got data=%h x=%0d y=%0d, required no valid pixel",
                        data, x, y);
            end else begin
               e = exp_q.pop_front();
               if ({data, x, y, sof, sol} !== e) begin
                  errors++;
                  $display("FAIL pixel: got data=%h x=%0d y=%0d sof=%0b sol=%0b, required data=%h x=%0d y=%0d sof=%0b sol=%0b",
                           data, x, y, sof, sol, e[W-1 -: PW], e[24:13], e[12:2], e[1], e[0]);
               end
            end
         end
      end
   end

   // Main sequence
   initial begin
      int rk;
      rst = 1'b1;
      {R, G, B} = '0;
      HSync = ~ACT;
      VSync = ~ACT;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      #2 rst = 1'b0;
      repeat (3) drive('0, ~ACT, ~ACT);

      // Lock from reset: frames 1 and 2 measure, frame 3 is emitted
      send_frame(P, P, V, 1'b0, -1, 0);
      send_frame(P, P, V, 1'b0, -1, 0);
      sof_n = 0;
      sol_n = 0;
      send_frame(P, P, V, 1'b1, -1, 0);
      check("a_locked", 32'(locked), 32'd1);
      check("a_htotal", 32'(htotal), 32'd16);
      check("a_vtotal", 32'(vtotal), 32'd8);
      check("a_sof_count", 32'(sof_n), 32'd1);
      check("a_sol_count", 32'(sol_n), 32'd4);
      check("a_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef VGA_RX_POLARITY_DETECT_EN
      check("a_hpol", 32'(hpol_o), 32'd0);
      check("a_vpol", 32'(vpol_o), 32'd0);
`endif

      // Line length changes to 17 in line 2 of frame 5: lock drops, relock in frame 7
      send_frame(P, P, V, 1'b1, -1, 0);
      send_frame(P, P + 1, 2, 1'b0, -1, 0);
      check("b_unlocked", 32'(locked), 32'd0);
      check("b_htotal_new", 32'(htotal), 32'd17);
      send_frame(P + 1, P + 1, V, 1'b0, -1, 0);
      send_frame(P + 1, P + 1, V, 1'b1, -1, 0);
      check("b_relocked", 32'(locked), 32'd1);
      check("b_htotal", 32'(htotal), 32'd17);
      check("b_vtotal", 32'(vtotal), 32'd8);
      check("b_sb_empty", 32'(exp_q.size()), 32'd0);

      // HSync stalls: timeout clears lock and totals
      repeat (4200) drive(PW'($urandom_range(0, 65535)), ~ACT, ~ACT);
      check("c_locked", 32'(locked), 32'd0);
      check("c_htotal", 32'(htotal), 32'd0);
      check("c_vtotal", 32'(vtotal), 32'd0);

      // Reset in the middle of an active line, then two full frames before output
      rk = $urandom_range(HSB + 1, HSB + HVA);
      send_frame(P, P, V, 1'b0, VSB + 2, rk);
      send_frame(P, P, V, 1'b0, -1, 0);
      send_frame(P, P, V, 1'b0, -1, 0);
      check("d_not_locked_yet", 32'(locked), 32'd0);
      send_frame(P, P, V, 1'b1, -1, 0);
      check("d_locked", 32'(locked), 32'd1);
      check("d_htotal", 32'(htotal), 32'd16);
      check("d_vtotal", 32'(vtotal), 32'd8);
      repeat (4) drive('0, ~ACT, ~ACT);
      check("d_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
